// File: rtl/axi_lite_regbank.sv
`default_nettype none
// =============================================================================
// axi_lite_regbank : AXI4-Lite slave, NUM_RW RW control + NUM_RO RO status regs
// Optional IRQ status/enable pair: define AXI_LITE_REGBANK_IRQ_EN
// Revision: 1.0
// =============================================================================
module axi_lite_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_RW-1:0]            wr_pulse,
  input  logic [NUM_RO*DATA_WIDTH-1:0] ro_in
`ifdef AXI_LITE_REGBANK_IRQ_EN
  ,
  input  logic [DATA_WIDTH-1:0]        irq_src,
  output logic                         irq
`endif
);

  localparam int         STRB_W       = DATA_WIDTH / 8;
  localparam int         LSB          = $clog2(STRB_W);
  localparam int         IDX_W        = ADDR_WIDTH - LSB;
  localparam int         IRQ_STAT_IDX = NUM_RW + NUM_RO;
  localparam int         IRQ_EN_IDX   = NUM_RW + NUM_RO + 1;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  logic                  active_q;
  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [DATA_WIDTH-1:0] regs_d [NUM_RW];
  logic [NUM_RW-1:0]     wr_pulse_q, wr_pulse_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      c_idx;
  logic [31:0]           c_sel, ar_sel;
  logic [DATA_WIDTH-1:0] c_data, c_mask;
  logic [STRB_W-1:0]     c_strb;
  logic                  unused_ok;

`ifdef AXI_LITE_REGBANK_IRQ_EN
  logic [DATA_WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [DATA_WIDTH-1:0] irq_clr;
  logic                  irq_q;
`endif

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  // active_q keeps every READY low until the first clock after reset release
  assign S_AXI_AWREADY = active_q & ~aw_full_q & ~bvalid_q;
  assign S_AXI_WREADY  = active_q & ~w_full_q & ~bvalid_q;
  assign S_AXI_ARREADY = active_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse      = wr_pulse_q;

  generate
    for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
  endgenerate

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  // A handshake arriving this cycle counts as a filled buffer, so commit never waits an extra cycle
  assign commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign c_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
  assign c_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign c_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;
  assign c_sel  = 32'(c_idx);
  assign ar_sel = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:LSB]);

  always_comb begin
    c_mask = '0;
    for (int k = 0; k < STRB_W; k++) c_mask[k*8 +: 8] = {8{c_strb[k]}};
  end

  always_comb begin
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
`ifdef AXI_LITE_REGBANK_IRQ_EN
    irq_en_d   = irq_en_q;
    irq_clr    = '0;
`endif
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
        if (c_sel == i) begin
          regs_d[i]     = (regs_q[i] & ~c_mask) | (c_data & c_mask);
          wr_pulse_d[i] = 1'b1;
          bresp_d       = RESP_OKAY;
        end
      end
`ifdef AXI_LITE_REGBANK_IRQ_EN
      if (c_sel == IRQ_STAT_IDX) begin
        irq_clr = c_data & c_mask;
        bresp_d = RESP_OKAY;
      end
      if (c_sel == IRQ_EN_IDX) begin
        irq_en_d = (irq_en_q & ~c_mask) | (c_data & c_mask);
        bresp_d  = RESP_OKAY;
      end
`endif
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
        if (ar_sel == i) begin
          rdata_d = regs_q[i];
          rresp_d = RESP_OKAY;
        end
      end
      for (int i = 0; i < NUM_RO; i++) begin
        if (ar_sel == NUM_RW + i) begin
          rdata_d = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
          rresp_d = RESP_OKAY;
        end
      end
`ifdef AXI_LITE_REGBANK_IRQ_EN
      if (ar_sel == IRQ_STAT_IDX) begin
        rdata_d = irq_stat_q;
        rresp_d = RESP_OKAY;
      end
      if (ar_sel == IRQ_EN_IDX) begin
        rdata_d = irq_en_q;
        rresp_d = RESP_OKAY;
      end
`endif
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      active_q   <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
    end else begin
      active_q   <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

`ifdef AXI_LITE_REGBANK_IRQ_EN
  // New sources are OR-ed in after the clear so a same-cycle set wins
  assign irq_stat_d = (irq_stat_q & ~irq_clr) | irq_src;
  assign irq        = irq_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regbank.sv
`default_nettype none
// tb_axi_lite_regbank: directed + randomized AXI4-Lite traffic checked against a register-file model.
module tb_axi_lite_regbank;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NRW = 4;
  localparam int NRO = 2;
  localparam int SW  = DW / 8;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [AW-1:0]     S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]        S_AXI_AWPROT, S_AXI_ARPROT;
  logic              S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0]     S_AXI_WDATA, S_AXI_RDATA;
  logic [SW-1:0]     S_AXI_WSTRB;
  logic [1:0]        S_AXI_BRESP, S_AXI_RRESP;
  logic              S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic              S_AXI_RVALID, S_AXI_RREADY;
  logic [NRW*DW-1:0] reg_out;
  logic [NRW-1:0]    wr_pulse;
  logic [NRO*DW-1:0] ro_in;
`ifdef AXI_LITE_REGBANK_IRQ_EN
  logic [DW-1:0]     irq_src;
  logic              irq;
  logic [DW-1:0]     m_stat, m_en;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] m_rw [NRW];

  always #5 ACLK = ~ACLK;

  axi_lite_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .ro_in(ro_in)
`ifdef AXI_LITE_REGBANK_IRQ_EN
    , .irq_src(irq_src), .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < SW; k++) if (strb[k]) r[k*8 +: 8] = data[k*8 +: 8];
    return r;
  endfunction

  task automatic expected_read(input int idx, output logic [DW-1:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b10;
    if (idx < NRW) begin
      d = m_rw[idx]; r = 2'b00;
    end else if (idx < NRW + NRO) begin
      d = ro_in[(idx-NRW)*DW +: DW]; r = 2'b00;
    end
`ifdef AXI_LITE_REGBANK_IRQ_EN
    else if (idx == NRW + NRO) begin
      d = m_stat; r = 2'b00;
    end else if (idx == NRW + NRO + 1) begin
      d = m_en; r = 2'b00;
    end
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {61'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd0);
    check({tag, "_valid_resp"}, {58'd0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP}, 64'd0);
    check({tag, "_rdata"}, 64'(S_AXI_RDATA), 64'd0);
    check({tag, "_wr_pulse"}, 64'(wr_pulse), 64'd0);
    for (int i = 0; i < NRW; i++) check({tag, "_reg_out"}, 64'(reg_out[i*DW +: DW]), 64'd0);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    int idx, cyc, lat;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [1:0] exp_resp;
    logic [NRW-1:0] exp_pulse;
    idx = int'(addr) / SW;
    exp_pulse = '0;
    exp_resp = 2'b10;
    if (idx < NRW) begin
      exp_resp = 2'b00;
      exp_pulse[idx] = 1'b1;
      m_rw[idx] = merge(m_rw[idx], data, strb);
    end
`ifdef AXI_LITE_REGBANK_IRQ_EN
    else if (idx == NRW + NRO) begin
      exp_resp = 2'b00;
      m_stat = m_stat & ~merge('0, data, strb);
    end else if (idx == NRW + NRO + 1) begin
      exp_resp = 2'b00;
      m_en = merge(m_en, data, strb);
    end
`endif
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge ACLK);
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      #1;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    check("aw_w_accepted", {62'd0, aw_done, w_done}, 64'd3);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    lat = 0;
    while (!S_AXI_BVALID && lat < 50) begin
      @(negedge ACLK);
      lat++;
    end
    if (aw_dly == w_dly) check("b_latency", 64'(lat), 64'd0);
    check("bvalid", 64'(S_AXI_BVALID), 64'd1);
    check("bresp", 64'(S_AXI_BRESP), 64'(exp_resp));
    check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
    if (idx < NRW) check("reg_out", 64'(reg_out[idx*DW +: DW]), 64'(m_rw[idx]));
    for (int i = 0; i < b_dly; i++) begin
      @(negedge ACLK);
      check("b_hold", {59'd0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY},
            {59'd0, 1'b1, exp_resp, 2'b00});
      check("wr_pulse_one_cycle", 64'(wr_pulse), 64'd0);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("b_done", 64'(S_AXI_BVALID), 64'd0);
    check("wr_pulse_after", 64'(wr_pulse), 64'd0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_dly);
    int idx, cyc;
    bit hs;
    logic [DW-1:0] exp_d;
    logic [1:0] exp_r;
    idx = int'(addr) / SW;
    expected_read(idx, exp_d, exp_r);
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      #1;
      hs = S_AXI_ARREADY;
      @(posedge ACLK);
      cyc++;
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid", 64'(S_AXI_RVALID), 64'd1);
    check("rdata", 64'(S_AXI_RDATA), 64'(exp_d));
    check("rresp", 64'(S_AXI_RRESP), 64'(exp_r));
    for (int i = 0; i < r_dly; i++) begin
      @(negedge ACLK);
      check("r_hold", {29'd0, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {29'd0, 1'b1, exp_r, exp_d});
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("r_done", 64'(S_AXI_RVALID), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] old_val;
    ARESETN = 1'b0;
    {S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWPROT, S_AXI_ARPROT} = '0;
    {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY} = '0;
    S_AXI_WDATA = '0;
    S_AXI_WSTRB = '0;
    ro_in = '0;
    for (int i = 0; i < NRW; i++) m_rw[i] = '0;
`ifdef AXI_LITE_REGBANK_IRQ_EN
    irq_src = '0;
    m_stat = '0;
    m_en = '0;
`endif
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("ready_after_reset", {61'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd7);

    for (int i = 0; i < NRW; i++) axi_write(AW'(i*4), DW'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NRW; i++) axi_read(AW'(i*4), 0);

    axi_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    axi_write(6'h00, 32'h11223344, 4'b0101, 0, 0, 0);
    axi_read(6'h00, 1);
    check("strobe_merge_model", 64'(m_rw[0]), 64'hAA22CC44);

    axi_write(6'h04, 32'h5A5A0001, 4'hF, 3, 0, 5);
    axi_write(6'h08, 32'h0BADF00D, 4'hF, 0, 0, 0);

    ro_in[DW-1:0] = 32'hDEADBEEF;
    ro_in[2*DW-1:DW] = 32'h01234567;
    axi_read(6'h10, 0);
    axi_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(6'h10, 0);
    axi_read(6'h14, 0);
    axi_read(6'h3C, 2);

    for (int n = 0; n < 80; n++) begin
      a = AW'($urandom_range(0, 63));
`ifdef AXI_LITE_REGBANK_IRQ_EN
      if (int'(a) / SW == NRW + NRO || int'(a) / SW == NRW + NRO + 1) a = a - AW'(8);
`endif
      if ($urandom_range(0, 7) == 0) ro_in = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, SW'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2));
    end

    // same-cycle commit and read of reg1, then reset with both responses pending
    old_val = m_rw[1];
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h04; S_AXI_ARADDR = 6'h04;
    S_AXI_WDATA = 32'hC0FFEE00; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    #1;
    check("ready_all", {61'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd7);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    m_rw[1] = 32'hC0FFEE00;
    check("both_pending", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'd3);
    check("read_pre_write", 64'(S_AXI_RDATA), 64'(old_val));
    check("reg1_written", 64'(reg_out[DW +: DW]), 64'(m_rw[1]));
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < NRW; i++) m_rw[i] = '0;
    @(negedge ACLK);
    check("no_b_after_reset", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'd0);
    for (int i = 0; i < NRW; i++) axi_read(AW'(i*4), 0);

`ifdef AXI_LITE_REGBANK_IRQ_EN
    @(negedge ACLK);
    irq_src = 32'h8;
    @(negedge ACLK);
    irq_src = '0;
    m_stat = 32'h8;
    @(negedge ACLK);
    check("irq_masked", 64'(irq), 64'd0);
    axi_read(AW'((NRW+NRO)*4), 0);
    axi_write(AW'((NRW+NRO+1)*4), 32'h8, 4'hF, 0, 0, 0);
    @(negedge ACLK);
    check("irq_set", 64'(irq), 64'd1);
    axi_write(AW'((NRW+NRO)*4), 32'h8, 4'hF, 0, 0, 0);
    check("irq_cleared", 64'(irq), 64'd0);
    axi_read(AW'((NRW+NRO)*4), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit slave register block inside bwt_ip.
Provides NUM_RW read/write control registers with byte strobes and NUM_RO read-only status registers.
- Independent AW/W acceptance; SLVERR on illegal access; per-register write pulses.
- Sits between the PS AXI GP interconnect and the BWT datapath control/status logic.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64.
ADDR_WIDTH, 6, AXI address width in bits.
NUM_RW, 4, number of read/write registers, 1..16.
NUM_RO, 2, number of read-only registers, 0..16.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_RW*DATA_WIDTH  RW register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_RW  one-cycle strobe per RW register on a successful write
ro_in  in  NUM_RO*DATA_WIDTH  RO register sources, sampled at read time

Behaviour:
- Reset (ARESETN low, asynchronous): every output and internal register is 0.
  - All READY, VALID, BRESP, RRESP, RDATA, reg_out and wr_pulse are 0.
  - AW/W buffers empty.
  - Deassertion is taken synchronously to ACLK.
  - Reset mid-transaction drops the transaction; no B or R is issued for it.
- Address decode: idx = addr[ADDR_WIDTH-1:LSB], with LSB = clog2(DATA_WIDTH/8). Low bits are ignored (unaligned addresses are truncated).
  - idx < NUM_RW: RW register.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO register.
  - Otherwise: unmapped.
- Write path:
  - AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
  - AW and W may handshake in either order or in the same cycle. Each one is held in its own one-entry buffer.
  - In the cycle both buffers are full: commit, clear both buffers, set BVALID=1 on the next edge.
    - AW and W in the same cycle: BVALID rises 1 cycle after the handshake.
  - RW target: each byte k is updated only where WSTRB[k]=1. BRESP=OKAY (2'b00). wr_pulse[idx]=1 for exactly the commit-result cycle.
  - RO or unmapped target: no state change, no pulse, BRESP=SLVERR (2'b10).
  - BVALID holds until BREADY. BREADY may already be high when BVALID rises.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake, RDATA/RRESP are registered and RVALID=1 on the next edge (latency 1).
  - RW target: reg value. RO target: ro_in slice sampled in the handshake cycle. Both give RRESP=OKAY.
  - Unmapped target: RDATA=0, RRESP=SLVERR.
  - RDATA/RRESP are held stable until the RREADY handshake.
  - Back-to-back reads: with RREADY held high, throughput is 1 read per 2 cycles.
- Simultaneous write commit and read of the same register in the same cycle: read returns the pre-write value.
- Read and write channels are otherwise fully independent.

Optional Feature:
Macro: AXI_LITE_REGBANK_IRQ_EN.
Defined:
- Adds ports irq_src (in, DATA_WIDTH) and irq (out, 1).
- Adds IRQ_STATUS at idx NUM_RW+NUM_RO:
  - Bit i is set on any cycle irq_src[i]=1.
  - Write-1-to-clear, respecting WSTRB; BRESP=OKAY.
  - Set wins over a clear in the same cycle.
- Adds IRQ_ENABLE at idx NUM_RW+NUM_RO+1: plain RW.
- irq = registered |(IRQ_STATUS & IRQ_ENABLE), 1 cycle after status/enable change. Reset value 0.

Not defined: no irq ports; those two indices are unmapped (SLVERR).

Test Plan:
- Defaults: write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC, then read back -> each BRESP=OKAY, RDATA 0x1..0x4 RRESP=OKAY, reg_out slices match, wr_pulse[i] high exactly 1 cycle each.
- Reg0=0xAABBCCDD; write 0x11223344 with WSTRB=4'b0101 -> reg0 reads 0xAA22CC44.
- W presented 3 cycles before AW; BREADY held low 5 cycles -> single commit after AW handshake; BVALID stable 5 cycles; AWREADY/WREADY low while BVALID; next write accepted after B handshake.
- ro_in[0]=0xDEADBEEF: read 0x10 -> 0xDEADBEEF OKAY; write 0x10 -> SLVERR, readback still 0xDEADBEEF; read 0x3C -> RDATA 0, SLVERR.
- Drop ARESETN for 1 cycle while BVALID=1 and RVALID=1 -> all outputs 0 immediately; after release all registers read 0.
- IRQ_EN, defaults: pulse irq_src[3]; write IRQ_ENABLE=0x8 -> irq=1; write 0x8 to IRQ_STATUS -> irq=0 one cycle later.
